// File: rtl/demux1_2_buffered.sv
// 1:2 stream demultiplexer: steers each tagged input word into one of two
// per-channel FIFOs and counts words routed to each channel (saturating).
module demux1_2_buffered #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  // Index 0 is channel 1, index 1 is channel 2.
  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr [2];
  logic [PTR_W-1:0] rd_ptr [2];
  logic [OCC_W-1:0] occ    [2];
  logic [CNT_W-1:0] cnt    [2];
  logic [1:0]       full;
  logic [1:0]       valid;
  logic [1:0]       ready;
  logic [1:0]       push;
  logic [1:0]       pop;

  assign ready = {out2_ready, out1_ready};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    full  = '0;
    valid = '0;
    push  = '0;
    pop   = '0;
    for (int ch = 0; ch < 2; ch++) begin
      full[ch]  = (occ[ch] == FULL_OCC);
      valid[ch] = (occ[ch] != '0);
      pop[ch]   = valid[ch] && ready[ch];
    end
    // Full blocks the push even if that channel pops this cycle.
    in_ready = in_sel ? !full[1] : !full[0];
    push[0]  = in_valid && in_ready && !in_sel;
    push[1]  = in_valid && in_ready &&  in_sel;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the storage array is deliberately reset so out*_data reads 0 after
  // reset; this makes it flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        wr_ptr[ch] <= '0;
        rd_ptr[ch] <= '0;
        occ[ch]    <= '0;
        cnt[ch]    <= '0;
        for (int i = 0; i < DEPTH; i++) mem[ch][i] <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (push[ch]) begin
          mem[ch][wr_ptr[ch]] <= in_data;
          wr_ptr[ch]          <= wr_ptr[ch] + 1'b1;
          if (cnt[ch] != '1) cnt[ch] <= cnt[ch] + 1'b1;
        end
        if (pop[ch]) rd_ptr[ch] <= rd_ptr[ch] + 1'b1;
        case ({push[ch], pop[ch]})
          2'b10:   occ[ch] <= occ[ch] + 1'b1;
          2'b01:   occ[ch] <= occ[ch] - 1'b1;
          default: occ[ch] <= occ[ch];
        endcase
      end
    end
  end

  assign out1_data  = mem[0][rd_ptr[0]];
  assign out2_data  = mem[1][rd_ptr[1]];
  assign out1_valid = valid[0];
  assign out2_valid = valid[1];
  assign cnt1       = cnt[0];
  assign cnt2       = cnt[1];

endmodule
